// File: rtl/tessia_pkg.sv
// Shared definitions for the execute/writeback flag stage: flag bit positions,
// branch condition codes, queue entry layout and the condition evaluator.
package tessia_pkg;

    localparam int unsigned DATA_W = 8;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [2:0] {
        ALWAYS = 3'b000,
        EQ     = 3'b001,
        NE     = 3'b010,
        LT     = 3'b011,
        GE     = 3'b100,
        CS     = 3'b101,
        VS     = 3'b110,
        NEVER  = 3'b111
    } cond_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [3:0]        rd;
        logic              wb_en;
        logic              taken;
    } ex_entry_t;

    function automatic logic cond_holds(input logic [2:0] cond, input logic [3:0] flags);
        logic hit;
        hit = 1'b0;
        case (cond_t'(cond))
            ALWAYS:  hit = 1'b1;
            EQ:      hit = flags[FLAG_Z];
            NE:      hit = ~flags[FLAG_Z];
            LT:      hit = flags[FLAG_N];
            GE:      hit = ~flags[FLAG_N];
            CS:      hit = flags[FLAG_C];
            VS:      hit = flags[FLAG_V];
            NEVER:   hit = 1'b0;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ex_skid_fifo.sv
// Two-entry FIFO of ex_entry_t with a registered head (zero when empty)
// and a registered not-full flag, so readiness never depends on pop combinationally.
module ex_skid_fifo
    import tessia_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  ex_entry_t  push_data,
    input  logic       pop,
    input  logic       clear,
    output ex_entry_t  head,
    output logic [1:0] count,
    output logic       not_full
);

    ex_entry_t  head_q, head_d;
    ex_entry_t  tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       not_full_q, not_full_d;
    logic       push_ok;
    logic       pop_ok;

    always_comb begin
        push_ok    = push & not_full_q;
        pop_ok     = pop & (count_q != 2'd0);
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (clear) begin
            head_d  = '0;
            count_d = '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = push_data;
                    end else begin
                        tail_d = push_data;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    // Second entry slides forward; an emptied head reads as zero.
                    head_d  = (count_q == 2'd2) ? tail_q : '0;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Push is only legal below full, so the queue holds exactly one entry here.
                    head_d = push_data;
                end
                default: begin
                end
            endcase
        end

        not_full_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            not_full_q <= 1'b1;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            not_full_q <= not_full_d;
        end
    end

    assign head     = head_q;
    assign count    = count_q;
    assign not_full = not_full_q;

endmodule

// File: rtl/ex_flag_stage.sv
// Execute-to-writeback stage: holds the architectural flags, resolves branches
// against them, queues results for writeback and counts taken branches.
module ex_flag_stage
    import tessia_pkg::*;
#(
    parameter int unsigned N     = DATA_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     alu_result,
    input  logic [3:0]       alu_flags,
    input  logic [3:0]       rd,
    input  logic             wb_en,
    input  logic             set_flags,
    input  logic             is_branch,
    input  logic [2:0]       cond,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic [3:0]       out_rd,
    output logic             out_wb_en,
    output logic             out_taken,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] taken_cnt
);

    logic [3:0]       flags_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic             accept;
    logic             pop;
    logic             taken;
    ex_entry_t        push_entry;
    ex_entry_t        head;
    logic [1:0]       count;
    logic             not_full;

    always_comb begin
        accept = in_valid & in_ready & ~flush;
        pop    = out_valid & out_ready & ~flush;
        // The condition reads the flags as they stand before this instruction's own update.
        taken  = is_branch & cond_holds(cond, flags_q);

        push_entry.result = alu_result;
        push_entry.rd     = rd;
        push_entry.wb_en  = wb_en;
        push_entry.taken  = taken;

        flags_d = flags_q;
        if (accept && set_flags) begin
            flags_d = alu_flags;
        end

        taken_cnt_d = taken_cnt_q;
        if (accept && taken && (taken_cnt_q != '1)) begin
            taken_cnt_d = taken_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q     <= '0;
            taken_cnt_q <= '0;
        end else begin
            flags_q     <= flags_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    ex_skid_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (flush),
        .head      (head),
        .count     (count),
        .not_full  (not_full)
    );

    assign in_ready   = not_full;
    assign out_valid  = (count != 2'd0);
    assign out_result = head.result;
    assign out_rd     = head.rd;
    assign out_wb_en  = head.wb_en;
    assign out_taken  = head.taken;
    assign taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_ex_flag_stage.sv
// Scenario bench for ex_flag_stage against a queue-based reference model.
module tb_ex_flag_stage;

    localparam int N     = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     alu_result;
    logic [3:0]       alu_flags;
    logic [3:0]       rd;
    logic             wb_en;
    logic             set_flags;
    logic             is_branch;
    logic [2:0]       cond;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_result;
    logic [3:0]       out_rd;
    logic             out_wb_en;
    logic             out_taken;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] taken_cnt;

    always #5 clk = ~clk;

    ex_flag_stage #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .rd         (rd),
        .wb_en      (wb_en),
        .set_flags  (set_flags),
        .is_branch  (is_branch),
        .cond       (cond),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_wb_en  (out_wb_en),
        .out_taken  (out_taken),
        .flags_q    (flags_q),
        .taken_cnt  (taken_cnt)
    );

    typedef struct {
        logic [7:0] result;
        logic [3:0] rd;
        logic       wb_en;
        logic       taken;
    } ent_t;

    ent_t       m_q[$];
    logic [3:0] m_flags = 4'b0;
    int         m_cnt   = 0;
    bit         m_acc   = 0;
    int         passed  = 0;
    int         total   = 0;

    // Branch truth table: flag vector is {N, Z, C, V}.
    function automatic bit cond_ok(input logic [2:0] c, input logic [3:0] f);
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return f[2];
            3'd2:    return !f[2];
            3'd3:    return f[3];
            3'd4:    return !f[3];
            3'd5:    return f[1];
            3'd6:    return f[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] rand_flags();
        int unsigned k;
        logic [3:0]  f;
        k = $urandom_range(0, 4);
        f = 4'b0;
        if (k != 0) f = 4'b0001 << (k - 1);
        return f;
    endfunction

    function automatic logic [23:0] exp_vec();
        ent_t h;
        h.result = 8'h0; h.rd = 4'h0; h.wb_en = 1'b0; h.taken = 1'b0;
        if (m_q.size() > 0) h = m_q[0];
        return {(m_q.size() > 0), (m_q.size() < 2), h.result, h.rd, h.wb_en, h.taken,
                m_flags, 4'(m_cnt)};
    endfunction

    function automatic logic [23:0] dut_vec();
        return {out_valid, in_ready, out_result, out_rd, out_wb_en, out_taken, flags_q, taken_cnt};
    endfunction

    task automatic drive(input logic v, input logic [7:0] res, input logic [3:0] r,
                         input logic wb, input logic sf, input logic [3:0] fl,
                         input logic br, input logic [2:0] c, input logic fsh,
                         input logic ordy);
        in_valid = v; alu_result = res; rd = r; wb_en = wb; set_flags = sf;
        alu_flags = fl; is_branch = br; cond = c; flush = fsh; out_ready = ordy;
    endtask

    // Advance one clock and apply the same inputs to the model.
    task automatic tick();
        int   n;
        ent_t e;
        @(posedge clk);
        #1;
        n     = m_q.size();
        m_acc = 1'b0;
        if (rst) begin
            m_q.delete();
            m_flags = 4'b0;
            m_cnt   = 0;
        end else if (flush) begin
            m_q.delete();
        end else begin
            if (n > 0 && out_ready) void'(m_q.pop_front());
            if (in_valid && n < 2) begin
                m_acc   = 1'b1;
                e.result = alu_result;
                e.rd     = rd;
                e.wb_en  = wb_en;
                e.taken  = is_branch && cond_ok(cond, m_flags);
                m_q.push_back(e);
                if (e.taken && m_cnt < 15) m_cnt++;
                if (set_flags) m_flags = alu_flags;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 8'h0, 4'h0, 0, 0, 4'h0, 0, 3'd0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (dut_vec() !== 24'h400000) $display("FAIL reset_state: got %h want %h", dut_vec(), 24'h400000);
        else passed++;
        total++;
        if (dut_vec() !== exp_vec()) $display("FAIL reset_model: got %h want %h", dut_vec(), exp_vec());
        else passed++;
    endtask

    task automatic test_single();
        drive(1, 8'h2A, 4'd3, 1, 1, 4'b0000, 0, 3'd0, 0, 0);
        tick();
        total++;
        if ({out_valid, out_result, out_rd, flags_q} !== {1'b1, 8'h2A, 4'd3, 4'b0000})
            $display("FAIL single_head: got %h want %h", {out_valid, out_result, out_rd, flags_q},
                     {1'b1, 8'h2A, 4'd3, 4'b0000});
        else passed++;
        drive(0, 8'h0, 4'h0, 0, 0, 4'h0, 0, 3'd0, 0, 1);
        tick();
        total++;
        if ({out_valid, out_result, out_rd, out_wb_en, out_taken} !== 15'h0)
            $display("FAIL single_pop: got %h want %h",
                     {out_valid, out_result, out_rd, out_wb_en, out_taken}, 15'h0);
        else passed++;
        total++;
        if (dut_vec() !== exp_vec()) $display("FAIL single_model: got %h want %h", dut_vec(), exp_vec());
        else passed++;
    endtask

    task automatic test_cmp_branch();
        drive(1, 8'h00, 4'd1, 0, 1, 4'b0100, 0, 3'd0, 0, 1);
        tick();
        drive(1, 8'h40, 4'd2, 0, 0, 4'b0000, 1, 3'd1, 0, 1);
        tick();
        total++;
        if ({out_taken, taken_cnt} !== {1'b1, 4'd1})
            $display("FAIL branch_eq: got %h want %h", {out_taken, taken_cnt}, {1'b1, 4'd1});
        else passed++;
        drive(1, 8'h00, 4'd1, 0, 1, 4'b0100, 0, 3'd0, 0, 1);
        tick();
        drive(1, 8'h41, 4'd2, 0, 0, 4'b0000, 1, 3'd2, 0, 1);
        tick();
        total++;
        if ({out_taken, taken_cnt} !== {1'b0, 4'd1})
            $display("FAIL branch_ne: got %h want %h", {out_taken, taken_cnt}, {1'b0, 4'd1});
        else passed++;
        total++;
        if (dut_vec() !== exp_vec()) $display("FAIL branch_model: got %h want %h", dut_vec(), exp_vec());
        else passed++;
        drive(0, 8'h0, 4'h0, 0, 0, 4'h0, 0, 3'd0, 0, 1);
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] vals[3];
        logic [7:0] got[$];
        int         k;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            if (k < 3) drive(1, vals[k], 4'(k + 4), 1, 0, 4'h0, 0, 3'd0, 0, (c >= 4));
            else       drive(0, 8'h0, 4'h0, 0, 0, 4'h0, 0, 3'd0, 0, 1);
            #1;
            if (out_valid && out_ready) got.push_back(out_result);
            tick();
            if (m_acc) k++;
            if (c == 1) begin
                total++;
                if (in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b want 0", in_ready);
                else passed++;
            end
            total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL bp_cycle%0d: got %h want %h", c, dut_vec(), exp_vec());
            else passed++;
        end
        total++;
        if (got.size() != 3 || got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33)
            $display("FAIL bp_order: got %p want 11 22 33", got);
        else passed++;
    endtask

    task automatic test_flush();
        drive(1, 8'h51, 4'd6, 1, 1, 4'b0010, 0, 3'd0, 0, 0);
        tick();
        drive(1, 8'h52, 4'd7, 1, 0, 4'b0000, 0, 3'd0, 0, 0);
        tick();
        drive(1, 8'h77, 4'd5, 1, 1, 4'b1000, 0, 3'd0, 1, 1);
        tick();
        total++;
        if ({out_valid, in_ready, flags_q} !== {1'b0, 1'b1, 4'b0010})
            $display("FAIL flush_state: got %h want %h", {out_valid, in_ready, flags_q},
                     {1'b0, 1'b1, 4'b0010});
        else passed++;
        total++;
        if (dut_vec() !== exp_vec()) $display("FAIL flush_model: got %h want %h", dut_vec(), exp_vec());
        else passed++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 17; i++) begin
            drive(1, 8'(i), 4'h9, 0, 0, 4'h0, 1, 3'd0, 0, 1);
            tick();
            total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL sat_step%0d: got %h want %h", i, dut_vec(), exp_vec());
            else passed++;
        end
        total++;
        if (taken_cnt !== 4'hF) $display("FAIL sat_value: got %h want f", taken_cnt);
        else passed++;
        drive(1, 8'hEE, 4'h1, 1, 1, 4'b0001, 0, 3'd0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({taken_cnt, flags_q, out_valid} !== 9'h0)
            $display("FAIL sat_reset: got %h want 0", {taken_cnt, flags_q, out_valid});
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0, 8'($urandom), 4'($urandom), 1'($urandom),
                  1'($urandom), rand_flags(), 1'($urandom), 3'($urandom),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
            tick();
            total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
            else passed++;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 8'h0, 4'h0, 0, 0, 4'h0, 0, 3'd0, 0, 0);
        test_reset();
        test_single();
        test_cmp_branch();
        test_backpressure();
        test_flush();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ex_flag_stage.md
# ex_flag_stage

Execute-to-writeback stage placed directly downstream of the 8-bit ALU. Each cycle it can capture one ALU result together with its 4-bit flag vector and destination tag. It keeps the architectural flag register, resolves branch conditions against that register, and buffers results in a 2-entry queue so the writeback side can apply backpressure. It also counts taken branches for performance monitoring.

## Interface
- N, 8, datapath width; must match the ALU result width
- CNT_W, 16, width of the taken-branch counter

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ALU output presents a valid instruction
- in_ready  out  1  stage can accept; registered
- alu_result  in  N  ALU result
- alu_flags  in  4  ALU flags: [3]=N, [2]=Z, [1]=C, [0]=V; at most one bit set
- rd  in  4  destination register index
- wb_en  in  1  instruction writes rd
- set_flags  in  1  instruction updates the flag register
- is_branch  in  1  instruction is a conditional branch
- cond  in  3  condition code (see Operation)
- flush  in  1  discard the queue and the current input
- out_valid  out  1  queue head is valid
- out_ready  in  1  writeback consumes the head
- out_result  out  N  head result
- out_rd  out  4  head destination
- out_wb_en  out  1  head write enable
- out_taken  out  1  head is a branch whose condition held
- flags_q  out  4  architectural flag register
- taken_cnt  out  CNT_W  saturating count of taken branches

## Operation
- Accept = in_valid & in_ready & !flush. Pop = out_valid & out_ready & !flush.
- Queue: 2 entries, FIFO order. Each entry holds {result, rd, wb_en, taken}.
  - Count transitions: push only +1; pop only -1; push and pop together leaves the count unchanged.
  - in_ready (next) = (next count < 2).
  - out_valid = (count != 0).
- Condition codes, always evaluated against flags_q as it stood before this instruction's own update:
  - 000 ALWAYS
  - 001 EQ: Z
  - 010 NE: !Z
  - 011 LT: N
  - 100 GE: !N
  - 101 CS: C
  - 110 VS: V
  - 111 NEVER
- taken = is_branch & cond_true. A non-branch entry always has taken = 0.
- On accept with set_flags = 1: flags_q <= alu_flags. This applies even when is_branch is also set; the condition still uses the old flags.
- On accept with taken = 1: taken_cnt += 1, saturating at 2^CNT_W-1.
- Flush:
  - Count becomes 0 and in_ready becomes 1.
  - The input in the same cycle is dropped: no flag update, no counter update.
  - flags_q and taken_cnt are retained.
- While out_valid = 0, out_result, out_rd, out_wb_en and out_taken are driven to 0.

## Timing
- Reset values:
  - out_valid = 0, in_ready = 1.
  - out_result = 0, out_rd = 0, out_wb_en = 0, out_taken = 0.
  - flags_q = 4'b0000, taken_cnt = 0.
  - Queue count = 0.
- Latency: an instruction accepted in cycle t appears at the head in cycle t+1 if the queue was empty.
- Throughput: 1 instruction per cycle while out_ready = 1.
- flags_q is visible in cycle t+1 after an accept in cycle t. A branch accepted in cycle t+1 therefore sees a compare accepted in cycle t.
- Full queue (count = 2): in_ready = 0. A pop in that cycle raises in_ready in the next cycle. There is no same-cycle combinational path from out_ready to in_ready.
- Flush takes priority over both push and pop. A flush in the same cycle as out_ready does not count as a pop.
- Reset in mid-operation empties the queue and clears flags_q and taken_cnt. It takes effect on the next clock edge.
- Payload outputs are registered from the queue head and change only on a pop, on a push into an empty queue, on a flush, or on reset.

## Structure
- Package tessia_pkg holds:
  - Flag bit indices FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
  - Enum cond_t: ALWAYS, EQ, NE, LT, GE, CS, VS, NEVER.
  - Packed struct ex_entry_t {result, rd, wb_en, taken}, parameterised by N through the package constant.
- Sub-module ex_skid_fifo is a generic 2-entry FIFO carrying ex_entry_t. It has push, pop, clear, count and a registered not-full output.
- The condition evaluator is a combinational function in tessia_pkg.

## Test plan
- Single instruction after reset:
  - Stimulus: accept {result=8'h2A, rd=3, wb_en=1, set_flags=1, flags=4'b0000}.
  - Next cycle: out_valid=1, out_result=8'h2A, out_rd=3, flags_q=0000.
  - Pop with out_ready=1 -> out_valid=0 and all payload outputs 0.
- Compare then branch:
  - Cycle t: accept set_flags=1, alu_flags=4'b0100.
  - Cycle t+1: accept branch with cond=EQ -> its head entry has out_taken=1 and taken_cnt=1.
  - Repeat with cond=NE -> out_taken=0 and taken_cnt unchanged.
- Backpressure:
  - Stimulus: hold out_ready=0 and offer 3 instructions back to back.
  - First 2 are accepted; in_ready=0 from the cycle after the second accept; the third is held.
  - Raise out_ready -> results come out in order 1, 2, 3 with no loss or duplication.
- Flush with a full queue and in_valid=1, set_flags=1, alu_flags=4'b1000:
  - Next cycle: out_valid=0, in_ready=1, flags_q unchanged.
  - A simultaneous out_ready=1 produces no pop.
- Counter saturation with CNT_W=4:
  - Stimulus: 17 taken branches (cond=ALWAYS) -> taken_cnt stays at 4'hF.
  - Synchronous rst asserted for one cycle -> taken_cnt=0, flags_q=0, out_valid=0.
